// File: rtl/edac_pkg.sv
// edac_pkg
//   Shared definitions for the CRC-based EDAC engine:
//   - status_e     : result status encoding presented on the status port
//   - init_state_e : states of the syndrome-table init FSM
//   - crc_calc     : width-generic MSB-first CRC (init 0, no reflection,
//                    no final XOR), used for both encode and syndrome math
package edac_pkg;

    // Upper bounds for the width-generic CRC helper.
    localparam int CRC_MAX_W  = 32;
    localparam int DATA_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_UNCORR = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2
    } init_state_e;

    // Bit-serial CRC over the low data_w bits of data, MSB first. The loop
    // runs over the fixed maximum width so it unrolls to a constant bound;
    // bits above data_w are skipped.
    function automatic logic [CRC_MAX_W-1:0] crc_calc(
        input logic [DATA_MAX_W-1:0] data,
        input int                    data_w,
        input int                    crc_w,
        input logic [CRC_MAX_W-1:0]  poly
    );
        logic [CRC_MAX_W-1:0] crc;
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] top;
        logic                 fb;
        crc  = '0;
        mask = (CRC_MAX_W'(1) << crc_w) - CRC_MAX_W'(1);
        top  = CRC_MAX_W'(1) << (crc_w - 1);
        for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
            if (i < data_w) begin
                fb  = (|(data & (DATA_MAX_W'(1) << i))) ^ (|(crc & top));
                crc = (crc << 1) & mask;
                if (fb) begin
                    crc = crc ^ (poly & mask);
                end
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/edac_syn_lut.sv
// edac_syn_lut
//   Single-port synchronous RAM holding the syndrome -> bit-position table.
//   Contents are not reset; the owner rebuilds them after every reset.
//   rdata is registered and only updates while en is high, so a stalled
//   pipeline keeps its lookup result.
// Ports:
//   clk   : clock
//   en    : port enable (read and/or write)
//   we    : write enable (qualified by en)
//   addr  : word address (the syndrome)
//   wdata : write data {valid, position}
//   rdata : registered read data
module edac_syn_lut #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 6
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/edac_crc_engine.sv
// edac_crc_engine
//   CRC-based single-bit error correction engine. Encode appends the CRC of
//   the payload; decode computes the syndrome, looks it up in a table built
//   at start-up, and corrects a single flipped bit or flags the word as
//   uncorrectable. Two-stage pipeline with valid/ready handshakes on both
//   sides, one word per cycle.
// Ports:
//   CLK, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake (in_ready low until init done)
//   READ                  : 1 = decode DIN, 0 = encode DIN[DATA_W-1:0]
//   DIN                   : input codeword / payload
//   out_valid/out_ready   : output handshake
//   DOUT, status          : result word, 00 clean / 01 corrected / 10 bad
//   corr_cnt, uncorr_cnt  : saturating error counters
//   clr_cnt               : synchronous counter clear (beats increments)
//   init_done             : syndrome table is built
module edac_crc_engine
    import edac_pkg::*;
#(
    parameter int                       DATA_W     = 24,
    parameter int                       CRC_W      = 8,
    parameter logic [CRC_W-1:0]         CRC_POLY   = 8'h97,
    parameter logic [DATA_W+CRC_W-1:0]  ERROR_CODE = '1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     READ,
    input  logic [DATA_W+CRC_W-1:0]  DIN,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+CRC_W-1:0]  DOUT,
    output logic [1:0]               status,
    output logic [15:0]              corr_cnt,
    output logic [15:0]              uncorr_cnt,
    input  logic                     clr_cnt,
    output logic                     init_done
);

    localparam int CW_W      = DATA_W + CRC_W;
    localparam int PW        = $clog2(CW_W);
    localparam int LUT_W     = 1 + PW;
    localparam int TBL_DEPTH = 1 << CRC_W;
    localparam int CNT_W     = (CRC_W > PW) ? CRC_W : PW;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [CRC_W-1:0] crc_of(input logic [DATA_W-1:0] pay);
        return CRC_W'(crc_calc(DATA_MAX_W'(pay), DATA_W, CRC_W, CRC_MAX_W'(CRC_POLY)));
    endfunction

    // ---------------------------------------------------------------
    // Init FSM: clear every table entry, then write one entry per
    // single-bit error position, then enable traffic.
    // ---------------------------------------------------------------
    init_state_e      state_q;
    logic [CNT_W-1:0] init_cnt_q;
    logic             init_done_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (init_cnt_q == CNT_W'(TBL_DEPTH - 1)) begin
                        state_q    <= S_FILL;
                        init_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_W'(1);
                    end
                end
                S_FILL: begin
                    if (init_cnt_q == CNT_W'(CW_W - 1)) begin
                        state_q     <= S_RUN;
                        init_cnt_q  <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_CLEAR;
                    init_cnt_q  <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = init_done_q;

    // Syndrome produced by a single flipped bit at the current fill position.
    logic [PW-1:0]    fill_pos;
    logic [CW_W-1:0]  fill_cw;
    logic [CRC_W-1:0] fill_syn;

    always_comb begin
        fill_pos = init_cnt_q[PW-1:0];
        fill_cw  = CW_W'(1) << fill_pos;
        fill_syn = crc_of(fill_cw[CW_W-1:CRC_W]) ^ fill_cw[CRC_W-1:0];
    end

    // ---------------------------------------------------------------
    // Stage 0 -> 1: CRC / syndrome of the offered word, table read.
    // ---------------------------------------------------------------
    logic             vld_p2_q;
    logic             advance;
    logic             accept;
    logic [DATA_W-1:0] pay_s0;
    logic [CRC_W-1:0] crc_s0;
    logic [CRC_W-1:0] syn_s0;

    assign advance  = !vld_p2_q || out_ready;
    assign in_ready = init_done_q && advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pay_s0 = READ ? DIN[CW_W-1:CRC_W] : DIN[DATA_W-1:0];
        crc_s0 = crc_of(pay_s0);
        syn_s0 = crc_s0 ^ DIN[CRC_W-1:0];
    end

    logic             lut_en;
    logic             lut_we;
    logic [CRC_W-1:0] lut_addr;
    logic [LUT_W-1:0] lut_wdata;
    logic [LUT_W-1:0] lut_rdata;

    // The table port is owned by the init FSM until RUN; afterwards it is a
    // read port that freezes with the pipeline.
    always_comb begin
        lut_en    = 1'b1;
        lut_we    = 1'b0;
        lut_addr  = syn_s0;
        lut_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                lut_we   = 1'b1;
                lut_addr = init_cnt_q[CRC_W-1:0];
            end
            S_FILL: begin
                lut_we    = 1'b1;
                lut_addr  = fill_syn;
                lut_wdata = {1'b1, fill_pos};
            end
            default: begin
                lut_en = advance;
            end
        endcase
    end

    edac_syn_lut #(
        .ADDR_W (CRC_W),
        .WORD_W (LUT_W)
    ) u_syn_lut (
        .clk   (CLK),
        .en    (lut_en),
        .we    (lut_we),
        .addr  (lut_addr),
        .wdata (lut_wdata),
        .rdata (lut_rdata)
    );

    logic             vld_p1_q, vld_p1_d;
    logic [CW_W-1:0]  din_p1_q, din_p1_d;
    logic             read_p1_q, read_p1_d;
    logic [CRC_W-1:0] crc_p1_q, crc_p1_d;

    always_comb begin
        vld_p1_d  = advance ? accept : vld_p1_q;
        din_p1_d  = advance ? DIN    : din_p1_q;
        read_p1_d = advance ? READ   : read_p1_q;
        crc_p1_d  = advance ? crc_s0 : crc_p1_q;
    end

    always_ff @(posedge CLK) begin
        din_p1_q  <= din_p1_d;
        read_p1_q <= read_p1_d;
        crc_p1_q  <= crc_p1_d;
    end

    // ---------------------------------------------------------------
    // Stage 1 -> 2: correction, result and counter registers.
    // ---------------------------------------------------------------
    logic [CRC_W-1:0] syn_p1;
    logic [CW_W-1:0]  res_dout;
    status_e          res_status;
    logic             res_corr;
    logic             res_uncorr;
    logic             commit;

    always_comb begin
        syn_p1     = crc_p1_q ^ din_p1_q[CRC_W-1:0];
        res_dout   = din_p1_q;
        res_status = ST_CLEAN;
        res_corr   = 1'b0;
        res_uncorr = 1'b0;
        if (!read_p1_q) begin
            res_dout = {din_p1_q[DATA_W-1:0], crc_p1_q};
        end else if (syn_p1 == '0) begin
            res_dout = din_p1_q;
        end else if (lut_rdata[PW]) begin
            res_dout   = din_p1_q ^ (CW_W'(1) << lut_rdata[PW-1:0]);
            res_status = ST_CORR;
            res_corr   = 1'b1;
        end else begin
            res_dout   = ERROR_CODE;
            res_status = ST_UNCORR;
            res_uncorr = 1'b1;
        end
        commit = advance && vld_p1_q;
    end

    logic            vld_p2_d;
    logic [CW_W-1:0] dout_p2_q, dout_p2_d;
    status_e         status_p2_q, status_p2_d;
    logic [15:0]     corr_cnt_q, corr_cnt_d;
    logic [15:0]     uncorr_cnt_q, uncorr_cnt_d;

    always_comb begin
        vld_p2_d    = advance ? vld_p1_q : vld_p2_q;
        dout_p2_d   = commit ? res_dout   : dout_p2_q;
        status_p2_d = commit ? res_status : status_p2_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            corr_cnt_d   = (commit && res_corr)   ? sat_inc(corr_cnt_q)   : corr_cnt_q;
            uncorr_cnt_d = (commit && res_uncorr) ? sat_inc(uncorr_cnt_q) : uncorr_cnt_q;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            dout_p2_q    <= '0;
            status_p2_q  <= ST_CLEAN;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            dout_p2_q    <= dout_p2_d;
            status_p2_q  <= status_p2_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = vld_p2_q;
    assign DOUT       = dout_p2_q;
    assign status     = status_p2_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_edac_crc_engine.sv
// tb_edac_crc_engine
//   Scoreboard bench for edac_crc_engine at default parameters. The driver
//   pushes the hand-computed expected result when a word is accepted; a
//   monitor on the falling edge pops and compares whenever a result is
//   consumed.
module tb_edac_crc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        READ = 1'b0;
    logic [31:0] DIN = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] DOUT;
    logic [1:0]  status;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        clr_cnt = 1'b0;
    logic        init_done;

    always #5 clk = ~clk;

    edac_crc_engine dut (
        .CLK        (clk),
        .reset      (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .READ       (READ),
        .DIN        (DIN),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .DOUT       (DOUT),
        .status     (status),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .clr_cnt    (clr_cnt),
        .init_done  (init_done)
    );

    typedef struct {
        logic [31:0] dout;
        logic [1:0]  st;
        logic [15:0] corr;
        logic [15:0] uncorr;
        int          id;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic [1:0]  st;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[12];
    int          n_checks = 0;
    int          n_err = 0;
    logic [15:0] m_corr = '0;
    logic [15:0] m_uncorr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per consumed result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got dout=%h status=%b, required no output", DOUT, status);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("out%0d_dout", mon_e.id), 64'(DOUT), 64'(mon_e.dout));
                check($sformatf("out%0d_status", mon_e.id), 64'(status), 64'(mon_e.st));
                check($sformatf("out%0d_counters", mon_e.id), 64'({corr_cnt, uncorr_cnt}),
                      64'({mon_e.corr, mon_e.uncorr}));
            end
        end
    end

    task automatic send(input vec_t v, input int id);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        READ     = v.rd;
        DIN      = v.din;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (clr_cnt) begin
                    m_corr   = '0;
                    m_uncorr = '0;
                end else if (v.st == 2'b01 && m_corr != 16'hFFFF) begin
                    m_corr = m_corr + 16'd1;
                end else if (v.st == 2'b10 && m_uncorr != 16'hFFFF) begin
                    m_uncorr = m_uncorr + 16'd1;
                end
                sb.push_back('{v.dout, v.st, m_corr, m_uncorr, id});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout_%0d: in_ready stayed 0, required 1", id);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(sb.size()), 64'(0));
    endtask

    task automatic wait_init(input string name);
        int  n;
        bit  saw_ready;
        n         = 0;
        saw_ready = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (init_done) break;
            if (in_ready) saw_ready = 1'b1;
        end
        check({name, "_init_cycles"}, 64'(n), 64'(288));
        check({name, "_in_ready_during_init"}, 64'(saw_ready), 64'(0));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, 64'(out_valid), 64'(0));
        check({name, "_in_ready"}, 64'(in_ready), 64'(0));
        check({name, "_dout"}, 64'(DOUT), 64'(0));
        check({name, "_status"}, 64'(status), 64'(0));
        check({name, "_counters"}, 64'({corr_cnt, uncorr_cnt}), 64'(0));
        check({name, "_init_done"}, 64'(init_done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h00000001, 32'h00000197, 2'b00};
        vecs[1]  = '{1'b1, 32'h00000196, 32'h00000197, 2'b01};
        vecs[2]  = '{1'b1, 32'h00000100, 32'h00000000, 2'b01};
        vecs[3]  = '{1'b1, 32'h00000003, 32'hFFFFFFFF, 2'b10};
        vecs[4]  = '{1'b1, 32'h00000197, 32'h00000197, 2'b00};
        vecs[5]  = '{1'b0, 32'hAB000003, 32'h0000032E, 2'b00};
        vecs[6]  = '{1'b1, 32'h80000000, 32'h00000000, 2'b01};
        vecs[7]  = '{1'b1, 32'h00000117, 32'h00000197, 2'b01};
        vecs[8]  = '{1'b1, 32'h00000101, 32'hFFFFFFFF, 2'b10};
        vecs[9]  = '{1'b1, 32'h0000032E, 32'h0000032E, 2'b00};
        vecs[10] = '{1'b0, 32'h00FFFFFF, 32'hFFFFFF5A, 2'b00};
        vecs[11] = '{1'b1, 32'hFFFFEF5A, 32'hFFFFFF5A, 2'b01};

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;
        wait_init("first");

        // Isolated encode with latency check.
        send(vecs[0], 0);
        in_valid = 1'b0;
        check("enc_latency_cycle1", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("enc_latency_cycle2", 64'(out_valid), 64'(1));
        drain("drain_single");

        // Back-to-back decode/encode mix.
        for (int i = 1; i < 12; i++) send(vecs[i], i);
        in_valid = 1'b0;
        drain("drain_mix");
        check("mix_corr_cnt", 64'(corr_cnt), 64'(5));
        check("mix_uncorr_cnt", 64'(uncorr_cnt), 64'(2));

        // Clear held across correcting/uncorrectable words: clear wins.
        clr_cnt = 1'b1;
        send(vecs[1], 101);
        send(vecs[3], 103);
        in_valid = 1'b0;
        drain("drain_clr");
        clr_cnt = 1'b0;
        m_corr   = '0;
        m_uncorr = '0;
        @(posedge clk);
        #1;
        check("clr_counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));

        // Stream with a 5-cycle output stall.
        fork
            begin
                for (int i = 0; i < 12; i++) send(vecs[i], 200 + i);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_corr_cnt", 64'(corr_cnt), 64'(5));

        // Reset in the middle of a stream.
        for (int i = 0; i < 4; i++) send(vecs[i], 300 + i);
        in_valid = 1'b0;
        check("pre_reset_inflight", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        sb.delete();
        m_corr   = '0;
        m_uncorr = '0;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("second");
        send(vecs[1], 400);
        in_valid = 1'b0;
        drain("drain_after_reset");
        check("after_reset_corr_cnt", 64'(corr_cnt), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/edac_crc_engine.md
EDAC_CRC_ENGINE -- requirements
Module: edac_crc_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24: payload width in bits.
REQ-002 The block SHALL have parameter CRC_W, default 8: check-field width in bits.
REQ-003 The block SHALL have parameter CRC_POLY, default 8'h97: generator polynomial (implicit x^CRC_W term).
REQ-004 The block SHALL have parameter ERROR_CODE, default all ones (CW_W bits): output on uncorrectable word; CW_W = DATA_W+CRC_W.
REQ-005 The block SHALL have port CLK, input, 1 bit: single system clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input word offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: input accepted when in_valid && in_ready.
REQ-009 The block SHALL have port READ, input, 1 bit: 1 = decode, 0 = encode; sampled with the input word.
REQ-010 The block SHALL have port DIN, input, CW_W bits: codeword for decode; payload in DIN[DATA_W-1:0] for encode.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-013 The block SHALL have port DOUT, output, CW_W bits: result word.
REQ-014 The block SHALL have port status, output, 2 bits: 00 clean/encoded, 01 corrected, 10 uncorrectable.
REQ-015 The block SHALL have ports corr_cnt and uncorr_cnt, output, 16 bits each: error counters.
REQ-016 The block SHALL have port clr_cnt, input, 1 bit: synchronous counter clear.
REQ-017 The block SHALL have port init_done, output, 1 bit: syndrome table built.

Function
REQ-018 Codeword SHALL be {payload, crc}; CRC MSB-first, init 0, no reflection, no final XOR.
REQ-019 Encode SHALL output {DIN[DATA_W-1:0], crc(DIN[DATA_W-1:0])} with status 00.
REQ-020 Decode syndrome SHALL be crc(received payload) XOR received check field.
REQ-021 Syndrome 0 SHALL output DIN unchanged, status 00.
REQ-022 Nonzero syndrome with a valid table entry p SHALL output DIN with bit p inverted, status 01, corr_cnt +1.
REQ-023 Nonzero syndrome with no valid entry SHALL output ERROR_CODE, status 10, uncorr_cnt +1.
REQ-024 Counters SHALL saturate at 16'hFFFF; clr_cnt wins over a same-cycle increment.
REQ-025 The pipeline SHALL have two stages: stage 1 computes the syndrome and issues the synchronous table read; stage 2 corrects and registers DOUT/status. Latency is 2 cycles from accept to out_valid.
REQ-026 advance = !out_valid || out_ready; both stages SHALL hold, including the table read data, when advance = 0. in_ready = init_done && advance. Throughput is 1 word/cycle.
REQ-027 The init FSM SHALL have states CLEAR -> FILL -> RUN. CLEAR writes invalid to all 2^CRC_W entries. FILL writes, for p = 0..CW_W-1, entry[syndrome of single error at p] = {valid, p}. RUN asserts init_done.
REQ-028 Init SHALL take exactly 2^CRC_W + CW_W cycles after reset release (288 cycles at defaults). in_ready SHALL be 0 throughout.
REQ-029 Parameters SHALL yield distinct single-error syndromes. With default parameters, payload bit i maps to x^(i+8) mod P and check bit j maps to 1<<j.

Reset
REQ-030 Reset SHALL force out_valid=0, in_ready=0, DOUT=0, status=00, counters=0, init_done=0 and FSM=CLEAR, and SHALL discard words in flight; mid-operation reset restarts init.
REQ-031 Table RAM contents SHALL NOT be reset; the CLEAR state rebuilds them.

Structure
REQ-032 Package edac_pkg SHALL hold the status encoding, the FSM state enum and the CRC function.
REQ-033 Sub-module edac_syn_lut SHALL be a single-port synchronous RAM, 2^CRC_W x (1+clog2(CW_W)).

Verification
REQ-034 Reset release -> init_done rises exactly 288 cycles later; in_ready is 0 before that.
REQ-035 Encode DIN=24'h000001 -> DOUT=32'h00000197, status 00, 2 cycles after accept.
REQ-036 Decode 32'h00000196 (check bit 0 flipped) -> DOUT=32'h00000197, status 01, corr_cnt=1.
REQ-037 Decode 32'h00000000 with payload bit 0 flipped (32'h00000100, syndrome 8'h97) -> DOUT=32'h00000000, status 01.
REQ-038 Decode 32'h00000003 (syndrome 8'h03) -> DOUT=32'hFFFFFFFF, status 10, uncorr_cnt=1.
REQ-039 Back-to-back stream with out_ready held 0 for 5 cycles -> no loss or duplication and order is kept; reset asserted mid-stream -> out_valid drops immediately and init repeats.
